// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: picks one of four result sources for the register-file write port.
// Fixed priority for PRIO_SRC, round-robin among the rest, with starvation override.
module wb_arbiter #(
    parameter int unsigned PRIO_SRC = 1,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned WAIT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [19:0] rd_in,
    input  logic        stall,
    output logic [3:0]  gnt,
    output logic [1:0]  WBSel,
    output logic [4:0]  rd_out,
    output logic        RegWEn
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        last_sel_q, last_sel_d;
    logic [WAIT_W-1:0] wait_q [4];
    logic [WAIT_W-1:0] wait_d [4];

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_vec;
    logic [4:0] grant_rd;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!stall && req != '0) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!grant_valid && i != PRIO_SRC && req[i] && wait_q[i] == MAX_W) begin
                    grant_valid = 1'b1;
                    grant_idx   = 2'(i);
                end
            end
            if (!grant_valid && req[PRIO_SRC]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(PRIO_SRC);
            end
            // Rotating search starts at ptr and wraps naturally in 2 bits.
            for (int unsigned k = 0; k < 4; k++) begin
                if (!grant_valid && (ptr_q + 2'(k)) != 2'(PRIO_SRC) && req[ptr_q + 2'(k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ptr_q + 2'(k);
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec = 4'b0001 << grant_idx;
        end
        grant_rd = rd_in[5*grant_idx +: 5];
    end

    // Reset gates the outputs combinationally so they drop mid-cycle.
    always_comb begin
        gnt    = '0;
        WBSel  = '0;
        rd_out = '0;
        RegWEn = 1'b0;
        if (!reset) begin
            if (grant_valid) begin
                gnt    = grant_vec;
                WBSel  = grant_idx;
                rd_out = grant_rd;
                RegWEn = (grant_rd != '0);
            end else begin
                WBSel  = last_sel_q;
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        last_sel_d = last_sel_q;
        if (grant_valid) begin
            last_sel_d = grant_idx;
            if (grant_idx != 2'(PRIO_SRC)) begin
                ptr_d = grant_idx + 2'd1;
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            wait_d[i] = wait_q[i];
            if (i == PRIO_SRC || grant_vec[i] || !req[i]) begin
                wait_d[i] = '0;
            end else if (!stall && wait_q[i] < MAX_W) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            last_sel_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            last_sel_q <= last_sel_d;
            for (int unsigned i = 0; i < 4; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-by-cycle vector table plus mid-cycle reset sequences.
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] rd_in;
    logic        stall;
    logic [3:0]  gnt;
    logic [1:0]  WBSel;
    logic [4:0]  rd_out;
    logic        RegWEn;

    int tests  = 0;
    int failed = 0;

    wb_arbiter #(
        .PRIO_SRC(1),
        .MAX_WAIT(3),
        .WAIT_W  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .rd_in (rd_in),
        .stall (stall),
        .gnt   (gnt),
        .WBSel (WBSel),
        .rd_out(rd_out),
        .RegWEn(RegWEn)
    );

    always #10 clk = ~clk;

    // rd3=4, rd2=3, rd1=5, rd0=1; the X0 variant zeroes source 2's destination
    localparam logic [19:0] RD    = {5'd4, 5'd3, 5'd5, 5'd1};
    localparam logic [19:0] RD_X0 = {5'd4, 5'd0, 5'd5, 5'd1};

    typedef struct {
        logic        rst;
        logic        stl;
        logic [3:0]  rq;
        logic [19:0] rd;
        logic [3:0]  e_gnt;
        logic [1:0]  e_sel;
        logic [4:0]  e_rd;
        logic        e_wen;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [3:0] q, input logic [19:0] d,
                       input logic [3:0] g, input logic [1:0] w, input logic [4:0] o, input logic e);
        vec_t v;
        v.rst = r; v.stl = s; v.rq = q; v.rd = d;
        v.e_gnt = g; v.e_sel = w; v.e_rd = o; v.e_wen = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] g, input logic [1:0] w,
                         input logic [4:0] o, input logic e);
        tests++;
        if (gnt !== g || WBSel !== w || rd_out !== o || RegWEn !== e) begin
            failed++;
            $display("FAIL %s: gnt=%b WBSel=%0d rd_out=%0d RegWEn=%b, expected gnt=%b WBSel=%0d rd_out=%0d RegWEn=%b",
                     nm, gnt, WBSel, rd_out, RegWEn, g, w, o, e);
        end
    endtask

    task automatic step(input logic [3:0] q, input logic [3:0] g, input logic [1:0] w,
                        input logic [4:0] o, input logic e, input string nm);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; req = q; rd_in = RD;
        #1;
        check(nm, g, w, o, e);
    endtask

    task automatic pulse_reset(input logic [3:0] g, input logic [1:0] w,
                               input logic [4:0] o, input logic e, input string nm);
        #1 reset = 1'b1;
        #1 check({nm, "_during"}, 4'b0000, 2'd0, 5'd0, 1'b0);
        #1 reset = 1'b0;
        #1 check({nm, "_after"}, g, w, o, e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 4'b1111; rd_in = RD;

        add(1, 0, 4'b1111, RD,    4'b0000, 2'd0, 5'd0, 0);
        add(0, 0, 4'b1111, RD,    4'b0010, 2'd1, 5'd5, 1);
        // round-robin among 0,2,3 with the priority source idle
        add(0, 0, 4'b1101, RD,    4'b0001, 2'd0, 5'd1, 1);
        add(0, 0, 4'b1101, RD,    4'b0100, 2'd2, 5'd3, 1);
        add(0, 0, 4'b1101, RD,    4'b1000, 2'd3, 5'd4, 1);
        add(0, 0, 4'b1101, RD,    4'b0001, 2'd0, 5'd1, 1);
        add(0, 0, 4'b1101, RD,    4'b0100, 2'd2, 5'd3, 1);
        add(0, 0, 4'b0100, RD_X0, 4'b0100, 2'd2, 5'd0, 0);
        add(0, 0, 4'b1101, RD,    4'b1000, 2'd3, 5'd4, 1);
        // stall: select holds at 3, wait[0] frozen at 1
        add(0, 1, 4'b0011, RD,    4'b0000, 2'd3, 5'd0, 0);
        add(0, 1, 4'b0011, RD,    4'b0000, 2'd3, 5'd0, 0);
        add(0, 1, 4'b0011, RD,    4'b0000, 2'd3, 5'd0, 0);
        add(0, 0, 4'b0011, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0011, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0011, RD,    4'b0001, 2'd0, 5'd1, 1);
        // full starvation cycle from a cleared counter
        add(0, 0, 4'b0011, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0011, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0011, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0011, RD,    4'b0001, 2'd0, 5'd1, 1);
        add(0, 0, 4'b0010, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0000, RD,    4'b0000, 2'd1, 5'd0, 0);
        // two sources starve together: lowest first, the other stays saturated
        add(0, 0, 4'b0111, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0111, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0111, RD,    4'b0010, 2'd1, 5'd5, 1);
        add(0, 0, 4'b0111, RD,    4'b0001, 2'd0, 5'd1, 1);
        add(0, 0, 4'b0111, RD,    4'b0100, 2'd2, 5'd3, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; stall = vecs[i].stl; req = vecs[i].rq; rd_in = vecs[i].rd;
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_rd, vecs[i].e_wen);
        end

        // ptr is 3 here; a mid-cycle reset must send the RR search back to source 0
        step(4'b1001, 4'b1000, 2'd3, 5'd4, 1, "ptr_pre_reset");
        pulse_reset(4'b0001, 2'd0, 5'd1, 1, "ptr_reset");

        // build wait[0]=2, reset mid-cycle, then three blocked cycles before override
        step(4'b0011, 4'b0010, 2'd1, 5'd5, 1, "wait_build1");
        step(4'b0011, 4'b0010, 2'd1, 5'd5, 1, "wait_build2");
        pulse_reset(4'b0010, 2'd1, 5'd5, 1, "wait_reset");
        step(4'b0011, 4'b0010, 2'd1, 5'd5, 1, "wait_post1");
        step(4'b0011, 4'b0010, 2'd1, 5'd5, 1, "wait_post2");
        step(4'b0011, 4'b0001, 2'd0, 5'd1, 1, "wait_starve");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
